// File: rtl/conware_pkg.sv
// Shared definitions for the Game-of-Life generation sequencer:
// state encoding and board-size helper.
package conware_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_DISPLAY = 2'd1;
  localparam state_t ST_ISSUE   = 2'd2;
  localparam state_t ST_COLLECT = 2'd3;

  // Number of cells on a board of the given geometry.
  function automatic int cells(input int width, input int height);
    return width * height;
  endfunction

endpackage

// File: rtl/conware_sequencer.sv
// Generation controller: holds the current board, accepts a seed, hands the
// board to the next-generation engine, collects the result and offers every
// new board to the pixel converter. Handshake outputs are decoded from the
// state register alone so no input valid/ready reaches an output.
module conware_sequencer
  import conware_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int HEIGHT    = 4,
  parameter int GEN_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [WIDTH*HEIGHT-1:0]   seed_data,
  input  logic                      seed_valid,
  output logic                      seed_ready,
  input  logic                      run,
  input  logic                      step,
  input  logic [GEN_WIDTH-1:0]      max_gen,
  output logic [WIDTH*HEIGHT-1:0]   eng_data,
  output logic                      eng_valid,
  input  logic                      eng_ready,
  input  logic [WIDTH*HEIGHT-1:0]   res_data,
  input  logic                      res_valid,
  output logic                      res_ready,
  output logic [WIDTH*HEIGHT-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [GEN_WIDTH-1:0]      generation,
  output logic                      busy,
  output logic                      done
);

  localparam int CELLS = cells(WIDTH, HEIGHT);

  localparam logic [GEN_WIDTH-1:0] GEN_ZERO = {GEN_WIDTH{1'b0}};
  localparam logic [GEN_WIDTH-1:0] GEN_ONE  = {{(GEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [GEN_WIDTH-1:0] GEN_MAX  = {GEN_WIDTH{1'b1}};

  state_t               state;
  logic [CELLS-1:0]     board;
  logic [GEN_WIDTH-1:0] gen_count;
  logic                 step_pending;
  logic                 loaded;
  logic                 limit_hit;
  logic                 issue_go;
  logic                 seed_take;

  // The limit is live: re-evaluated every cycle against the current max_gen.
  assign limit_hit = (max_gen != GEN_ZERO) && (gen_count == max_gen);
  assign seed_take = (state == ST_IDLE) && seed_valid;
  assign issue_go  = loaded && !limit_hit && (run || step_pending);

  // Main control FSM with board and generation counter updates.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      board     <= {CELLS{1'b0}};
      gen_count <= GEN_ZERO;
      loaded    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (seed_valid) begin
            board     <= seed_data;
            gen_count <= GEN_ZERO;
            loaded    <= 1'b1;
            state     <= ST_DISPLAY;
          end else if (issue_go) begin
            state <= ST_ISSUE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DISPLAY: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_DISPLAY;
          end
        end
        ST_ISSUE: begin
          if (eng_ready) begin
            state <= ST_COLLECT;
          end else begin
            state <= ST_ISSUE;
          end
        end
        ST_COLLECT: begin
          if (res_valid) begin
            board <= res_data;
            if (gen_count != GEN_MAX) begin
              gen_count <= gen_count + GEN_ONE;
            end else begin
              gen_count <= gen_count;
            end
            state <= ST_DISPLAY;
          end else begin
            state <= ST_COLLECT;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Single-step request latch: pulses merge until the next issue consumes them;
  // a seed or an issue clears it and takes precedence over a same-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      step_pending <= 1'b0;
    end else if (seed_take) begin
      step_pending <= 1'b0;
    end else if ((state == ST_IDLE) && issue_go) begin
      step_pending <= 1'b0;
    end else if (step && loaded && !limit_hit) begin
      step_pending <= 1'b1;
    end else begin
      step_pending <= step_pending;
    end
  end

  assign seed_ready = (state == ST_IDLE);
  assign out_valid  = (state == ST_DISPLAY);
  assign eng_valid  = (state == ST_ISSUE);
  assign res_ready  = (state == ST_COLLECT);
  assign busy       = (state != ST_IDLE);
  assign out_data   = board;
  assign eng_data   = board;
  assign generation = gen_count;
  assign done       = limit_hit;

endmodule

// File: tb/tb_conware_sequencer.sv
// Self-checking bench for conware_sequencer: behavioural engine and converter
// models with configurable delays, and a Game-of-Life reference that predicts
// the board sequence the sequencer must hand out.
module tb_conware_sequencer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int GW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  seed_data;
  logic          seed_valid;
  logic          seed_ready;
  logic          run;
  logic          step;
  logic [GW-1:0] max_gen;
  logic [N-1:0]  eng_data;
  logic          eng_valid;
  logic          eng_ready;
  logic [N-1:0]  res_data;
  logic          res_valid;
  logic          res_ready;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [GW-1:0] generation;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  int eng_delay = 0;
  int res_delay = 0;
  int out_delay = 0;

  logic [N-1:0] eng_log[$];
  logic [N-1:0] out_log[$];

  conware_sequencer #(.WIDTH(W), .HEIGHT(H), .GEN_WIDTH(GW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .seed_data  (seed_data),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .run        (run),
    .step       (step),
    .max_gen    (max_gen),
    .eng_data   (eng_data),
    .eng_valid  (eng_valid),
    .eng_ready  (eng_ready),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .generation (generation),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Game-of-Life rule with dead cells beyond the board edge.
  function automatic logic [N-1:0] next_gen(input logic [N-1:0] b);
    logic [N-1:0] r;
    int n;
    r = '0;
    for (int row = 0; row < H; row++) begin
      for (int col = 0; col < W; col++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && row + dr >= 0 && row + dr < H &&
                col + dc >= 0 && col + dc < W && b[(row + dr) * W + col + dc])
              n++;
          end
        end
        r[row * W + col] = b[row * W + col] ? (n == 2 || n == 3) : (n == 3);
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction logger on the handshake edges.
  always @(posedge clk) begin
    if (rstn === 1'b1) begin
      if (eng_valid && eng_ready) eng_log.push_back(eng_data);
      if (out_valid && out_ready) out_log.push_back(out_data);
    end
  end

  // Behavioural next-generation engine with configurable ready/valid delays.
  initial begin : conware_step_model
    logic [N-1:0] job;
    eng_ready = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    forever begin
      @(negedge clk);
      if (eng_valid === 1'b1) begin
        job = eng_data;
        for (int i = 0; i < eng_delay; i++) begin
          @(negedge clk);
          chk("eng_hold_valid", eng_valid, 1);
          chk("eng_hold_data", eng_data, job);
        end
        eng_ready = 1'b1;
        @(negedge clk);
        eng_ready = 1'b0;
        repeat (res_delay) @(negedge clk);
        res_data  = next_gen(job);
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
      end
    end
  end

  // Pixel converter model with configurable backpressure.
  initial begin : converter_model
    logic [N-1:0] shown;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        shown = out_data;
        for (int i = 0; i < out_delay; i++) begin
          @(negedge clk);
          chk("out_hold_valid", out_valid, 1);
          chk("out_hold_data", out_data, shown);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seed_ready"}, seed_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_eng_valid"}, eng_valid, 0);
    chk({tag, "_res_ready"}, res_ready, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_eng_data"}, eng_data, 0);
    chk({tag, "_generation"}, generation, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int cnt = 0;
    while (busy !== 1'b0 && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    chk(tag, cnt < budget, 1);
  endtask

  task automatic wait_settle(input logic [GW-1:0] target, input int budget, input string tag);
    int cnt = 0;
    while ((generation !== target || busy !== 1'b0) && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    chk(tag, cnt < budget, 1);
  endtask

  task automatic wait_collect(input string tag);
    int cnt = 0;
    while (res_ready !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk(tag, cnt < 100, 1);
  endtask

  task automatic do_seed(input logic [N-1:0] s);
    eng_log.delete();
    out_log.delete();
    seed_data  = s;
    seed_valid = 1'b1;
    @(negedge clk);
    seed_valid = 1'b0;
    chk("seed_out_valid", out_valid, 1);
    chk("seed_out_data", out_data, s);
    chk("seed_generation", generation, 0);
    wait_idle("seed_idle_timeout", 100);
  endtask

  // Compare logged traffic with the reference generation sequence from s.
  task automatic check_seq(input logic [N-1:0] s, input int n, input string tag);
    logic [N-1:0] b;
    b = s;
    chk({tag, "_eng_count"}, eng_log.size(), n);
    chk({tag, "_out_count"}, out_log.size(), n + 1);
    if (out_log.size() > 0) chk({tag, "_out_seed"}, out_log[0], s);
    for (int i = 0; i < n; i++) begin
      if (i < eng_log.size()) chk({tag, "_eng_board"}, eng_log[i], b);
      b = next_gen(b);
      if (i + 1 < out_log.size()) chk({tag, "_out_board"}, out_log[i + 1], b);
    end
    chk({tag, "_final_board"}, out_data, b);
    chk({tag, "_final_gen"}, generation, n);
  endtask

  initial begin : main
    logic [N-1:0] s;
    int mg;

    rstn       = 1'b0;
    seed_data  = '0;
    seed_valid = 1'b0;
    run        = 1'b0;
    step       = 1'b0;
    max_gen    = '0;
    tick(3);
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick(1);

    // No effect before the first seed.
    pulse_step();
    run = 1'b1;
    tick(10);
    run = 1'b0;
    chk("preseed_eng_count", eng_log.size(), 0);
    chk("preseed_busy", busy, 0);

    // Seed display.
    do_seed(16'h0070);
    chk("seed_busy", busy, 0);
    chk("seed_ready_idle", seed_ready, 1);
    chk("seed_out_count", out_log.size(), 1);
    if (out_log.size() > 0) chk("seed_out_log", out_log[0], 16'h0070);

    // Single step on the blinker.
    pulse_step();
    wait_settle(1, 100, "step1_timeout");
    chk("step1_eng_count", eng_log.size(), 1);
    if (eng_log.size() > 0) chk("step1_eng_board", eng_log[0], 16'h0070);
    chk("step1_out_data", out_data, 16'h0222);
    chk("step1_generation", generation, 1);
    pulse_step();
    wait_settle(2, 100, "step2_timeout");
    chk("step2_out_data", out_data, 16'h0070);
    chk("step2_generation", generation, 2);

    // Generation limit.
    do_seed(16'h0070);
    max_gen = 5;
    run = 1'b1;
    wait_settle(5, 400, "limit_timeout");
    tick(10);
    check_seq(16'h0070, 5, "limit");
    chk("limit_done", done, 1);
    run = 1'b0;
    pulse_step();
    tick(2);
    pulse_step();
    tick(15);
    chk("limit_hold_gen", generation, 5);
    chk("limit_hold_eng", eng_log.size(), 5);
    chk("limit_hold_busy", busy, 0);
    max_gen = 3;
    #1;
    chk("limit_lowered_done", done, 0);
    max_gen = 5;
    #1;
    chk("limit_restored_done", done, 1);

    // Randomised free runs with random engine/converter latency.
    for (int k = 0; k < 3; k++) begin
      eng_delay = $urandom_range(0, 3);
      res_delay = $urandom_range(0, 3);
      out_delay = $urandom_range(0, 3);
      s  = N'($urandom);
      mg = $urandom_range(2, 6);
      max_gen = GW'(mg);
      do_seed(s);
      run = 1'b1;
      wait_settle(GW'(mg), 800, "rand_timeout");
      run = 1'b0;
      tick(5);
      check_seq(s, mg, "rand");
    end

    // Backpressure on both channels.
    eng_delay = 7;
    res_delay = 2;
    out_delay = 10;
    s = N'($urandom);
    max_gen = 3;
    do_seed(s);
    run = 1'b1;
    wait_settle(3, 1000, "bp_timeout");
    run = 1'b0;
    tick(5);
    check_seq(s, 3, "bp");

    // Seed wins over run in IDLE.
    eng_delay = 0;
    res_delay = 0;
    out_delay = 0;
    max_gen = 0;
    s = N'($urandom);
    eng_log.delete();
    out_log.delete();
    seed_data  = s;
    seed_valid = 1'b1;
    run        = 1'b1;
    @(negedge clk);
    seed_valid = 1'b0;
    run        = 1'b0;
    chk("prio_out_valid", out_valid, 1);
    chk("prio_out_data", out_data, s);
    chk("prio_generation", generation, 0);
    tick(10);
    chk("prio_hold_gen", generation, 0);
    chk("prio_eng_count", eng_log.size(), 0);

    // Step pulses during COLLECT merge into one more generation.
    res_delay = 10;
    pulse_step();
    wait_collect("merge_collect_timeout");
    for (int i = 0; i < 3; i++) begin
      pulse_step();
      tick(1);
    end
    wait_settle(2, 200, "merge_timeout");
    tick(20);
    chk("merge_generation", generation, 2);
    chk("merge_eng_count", eng_log.size(), 2);
    if (eng_log.size() > 1) chk("merge_eng_board", eng_log[1], next_gen(s));
    chk("merge_out_data", out_data, next_gen(next_gen(s)));

    // Reset while the engine result is outstanding.
    pulse_step();
    wait_collect("rst_collect_timeout");
    rstn = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rstn = 1'b1;
    tick(20);
    eng_log.delete();
    pulse_step();
    run = 1'b1;
    tick(15);
    run = 1'b0;
    chk("rst_noseed_eng", eng_log.size(), 0);
    chk("rst_noseed_gen", generation, 0);
    chk("rst_noseed_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conware_sequencer.md
# conware_sequencer

Generation controller for the Game-of-Life datapath. It holds the current board, loads a seed board, and hands the board to the next-generation compute engine over a valid/ready channel. It collects the result and presents every new board to the board-to-AXIS pixel converter. It also provides run/single-step control, a generation counter and an optional generation limit.

## Interface
- `WIDTH`, default 4: board columns.
- `HEIGHT`, default 4: board rows. Cell index is `row*WIDTH+col`.
- `GEN_WIDTH`, default 32: width of the generation counter and of `max_gen`.
- `clk`, in, 1: clock.
- `rstn`, in, 1: reset; synchronous, active-low.
- `seed_data`, in, `WIDTH*HEIGHT`: initial board, 1 = alive.
- `seed_valid`, in, 1: seed offered.
- `seed_ready`, out, 1: seed accepted when `seed_valid && seed_ready`.
- `run`, in, 1: level; free-run generations while high.
- `step`, in, 1: one-cycle pulse; request exactly one generation.
- `max_gen`, in, `GEN_WIDTH`: generation limit; 0 = unlimited.
- `eng_data`, out, `WIDTH*HEIGHT`: current board to the compute engine.
- `eng_valid`, out, 1: board offered to the engine.
- `eng_ready`, in, 1: engine accepts the board.
- `res_data`, in, `WIDTH*HEIGHT`: next-generation board from the engine.
- `res_valid`, in, 1: result offered.
- `res_ready`, out, 1: result accepted.
- `out_data`, out, `WIDTH*HEIGHT`: board to the pixel converter.
- `out_valid`, out, 1: board offered to the converter.
- `out_ready`, in, 1: converter accepts the board.
- `generation`, out, `GEN_WIDTH`: generations computed since the last seed.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: `max_gen != 0 && generation == max_gen`.

## Operation
- **Registers:** `board`, `generation`, `step_pending`, `loaded`, state.
- **States:** IDLE, DISPLAY, ISSUE, COLLECT.
- **IDLE** (`seed_ready=1`):
  - Seed has priority. On `seed_valid`: `board<=seed_data`, `generation<=0`, `loaded<=1`, `step_pending<=0`, go to DISPLAY.
  - Otherwise, if `loaded && !done && (run || step_pending)`, go to ISSUE and clear `step_pending`.
  - Otherwise stay in IDLE.
- **DISPLAY** (`out_valid=1`, `out_data=board`): on `out_ready`, go to IDLE.
- **ISSUE** (`eng_valid=1`, `eng_data=board`): on `eng_ready`, go to COLLECT.
- **COLLECT** (`res_ready=1`): on `res_valid`:
  - `board<=res_data`.
  - `generation<=generation+1`, saturating at all-ones.
  - Go to DISPLAY.
- **step pulse:**
  - Latched into `step_pending` in any state if `loaded && !done`; otherwise dropped.
  - Repeated pulses before an issue merge into one request.
- **step and run together:** only one generation is issued per IDLE visit, and `step_pending` is cleared by that issue.
- **Changing `max_gen`:** `done` is re-evaluated every cycle. If `max_gen` is lowered below `generation`, `done=0`; running continues until the counter saturates.
- **Before the first seed** (`loaded=0`): `run` and `step` have no effect.
- **`seed_valid` outside IDLE:** not accepted; `seed_ready=0`.

## Timing
- **Reset values:**
  - All valids/readies 0, except `seed_ready=1`.
  - `out_data`, `eng_data`, `board` = 0.
  - `generation` = 0; `busy`, `done` = 0; state IDLE.
  - `loaded`, `step_pending` = 0.
- **Output decoding:** all handshake outputs are decoded from the state register only. No combinational path from any `*_ready`/`*_valid` input to any output.
- **Seed latency:** seed accepted at edge t → `out_valid=1` with the seed from t+1.
- **Issue latency:** IDLE→ISSUE decided at edge t → `eng_valid=1` from t+1.
- **Result latency:** result accepted at edge t → `out_valid`, new `board`, and incremented `generation` all visible from t+1.
- **Stability:** `out_data`/`eng_data` are held stable while the corresponding valid is high and not yet accepted.
- **Best-case loop:** `run` high with engine and converter always ready gives 4 cycles per generation (IDLE, ISSUE, COLLECT, DISPLAY).
- **Reset mid-operation:** reset in any state returns to IDLE on the next edge. Any pending handshake is abandoned and `board` is cleared.

## Structure
- **Package `conware_pkg`:**
  - state enum (IDLE, DISPLAY, ISSUE, COLLECT);
  - `CELLS = WIDTH*HEIGHT` helper.
- **RTL:** single module, no sub-module.
- **Bench:** the testbench supplies a behavioural engine model `conware_step_model` with toroidal-free edges (cells outside the board are dead) and configurable ready/valid delays.

## Test plan
- **Seed display:** seed `16'h0070`, `out_ready=1` → `out_valid` one cycle after acceptance with `out_data=16'h0070`; `generation=0`; IDLE with `busy=0`.
- **Single step (blinker):** `step` pulse → engine sees `16'h0070`; model returns `16'h0222` → `out_data=16'h0222`, `generation=1`. A second step → `16'h0070`, `generation=2`.
- **Limit:** `run=1`, `max_gen=5` → exactly 5 engine transactions, then `done=1`. Further `step` pulses are ignored; `generation` holds at 5.
- **Backpressure:** `out_ready` low for 10 cycles and `eng_ready` low for 7 cycles → valids stay high and data stays stable throughout, and no generation is skipped or duplicated.
- **Priority and merging:** `seed_valid` and `run` both high in IDLE → seed loaded, `generation=0`. Three `step` pulses during COLLECT → exactly one further generation.
- **Reset mid-operation:** `rstn` low in COLLECT → next cycle all outputs at reset values. `step` before a new seed → no engine activity.
